// File: rtl/system_memory_ctrl_pkg.sv
// Shared types and state encoding for the grid-store sequencer.
package system_memory_ctrl_pkg;

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_LOAD   = 2'd1;
  localparam logic [1:0] STATE_RUN    = 2'd2;
  localparam logic [1:0] STATE_OUTPUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = STATE_IDLE,
    LOAD   = STATE_LOAD,
    RUN    = STATE_RUN,
    OUTPUT = STATE_OUTPUT
  } ctrl_state_t;

endpackage

// File: rtl/system_memory_ctrl.sv
// Sequencer for the grid store: turns host requests into LOAD/RUN/OUTPUT mode
// strobes, counts bits and generations, and pulses DONE on completion.
module system_memory_ctrl
  import system_memory_ctrl_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 5,
  parameter int unsigned GEN_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 LOAD_REQ,
  input  logic                 RUN_REQ,
  input  logic                 OUTPUT_REQ,
  input  logic [GEN_WIDTH-1:0] GENERATIONS,
  input  logic                 ABORT,
  input  logic                 SERIAL_IN_VALID,
  output logic                 SERIAL_IN_READY,
  input  logic                 OUTPUT_READY,
  output logic                 SERIAL_OUT_VALID,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [1:0]           STATE
);

  localparam int unsigned BitW = $clog2(DATA_SIZE + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_SIZE - 1);

  ctrl_state_t          state_q, state_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GEN_WIDTH-1:0] gen_cnt_q, gen_cnt_d;
  logic                 done_q, done_d;
  logic                 sov_q, sov_d;

  // Mode strobes: load/output gated by the handshake, run decoded from state.
  always_comb begin
    LOAD_MODE       = (state_q == LOAD) && SERIAL_IN_VALID;
    RUN_MODE        = (state_q == RUN);
    OUTPUT_MODE     = (state_q == OUTPUT) && OUTPUT_READY;
    SERIAL_IN_READY = (state_q == LOAD);
    BUSY            = (state_q != IDLE);
    STATE           = state_q;
    DONE            = done_q;
    SERIAL_OUT_VALID = sov_q;
  end

  // Next-state, counter and completion-pulse logic; ABORT overrides everything.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gen_cnt_d = gen_cnt_q;
    done_d    = 1'b0;
    // Memory SERIAL_OUT changes on the shift edge, so valid trails by one cycle.
    sov_d     = OUTPUT_MODE;

    if (ABORT) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      gen_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (RUN_REQ) begin
            if (GENERATIONS == '0) begin
              // Zero-length run completes without ever entering RUN.
              done_d = 1'b1;
            end else begin
              state_d   = RUN;
              gen_cnt_d = GENERATIONS;
            end
          end else if (LOAD_REQ) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
          end else if (OUTPUT_REQ) begin
            state_d   = OUTPUT;
            bit_cnt_d = '0;
          end
        end
        LOAD: begin
          if (SERIAL_IN_VALID) begin
            if (bit_cnt_q == LastBit) begin
              state_d   = IDLE;
              bit_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BitW'(1);
            end
          end
        end
        RUN: begin
          if (gen_cnt_q != '0) begin
            gen_cnt_d = gen_cnt_q - GEN_WIDTH'(1);
          end
          if (gen_cnt_q <= GEN_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        OUTPUT: begin
          if (OUTPUT_READY) begin
            if (bit_cnt_q == LastBit) begin
              state_d   = IDLE;
              bit_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BitW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gen_cnt_q <= '0;
      done_q    <= 1'b0;
      sov_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gen_cnt_q <= gen_cnt_d;
      done_q    <= done_d;
      sov_q     <= sov_d;
    end
  end

endmodule
